// File: rtl/vp_mult_pkg.sv
// vp_mult_pkg: shared widths, Booth select encoding and partial-product
// select type for the masked Booth mantissa multiplier.
package vp_mult_pkg;

    typedef struct packed {
        logic neg;
        logic two;
        logic one;
    } pp_t;

    localparam pp_t SEL_ZERO = pp_t'(3'b000);
    localparam pp_t SEL_POS1 = pp_t'(3'b001);
    localparam pp_t SEL_POS2 = pp_t'(3'b010);
    localparam pp_t SEL_NEG1 = pp_t'(3'b101);
    localparam pp_t SEL_NEG2 = pp_t'(3'b110);

    function automatic int prod_w(input int mant_w);
        return 2 * mant_w + 1;
    endfunction

    function automatic int mask_w(input int mant_w, input int trunc_lsb);
        return prod_w(mant_w) - trunc_lsb - 1;
    endfunction

    // ceil((mant_w+1)/2) radix-4 digits cover the zero-extended magnitude
    function automatic int num_pp(input int mant_w);
        return (mant_w + 2) / 2;
    endfunction

    function automatic pp_t booth_sel(input logic [2:0] grp);
        case (grp)
            3'b001, 3'b010: return SEL_POS1;
            3'b011:         return SEL_POS2;
            3'b100:         return SEL_NEG2;
            3'b101, 3'b110: return SEL_NEG1;
            default:        return SEL_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/vp_booth_pp.sv
// vp_booth_pp: one radix-4 Booth partial product of an unsigned
// magnitude, returned as a (MANT_W+3)-bit two's-complement value.
module vp_booth_pp
    import vp_mult_pkg::*;
#(
    parameter int MANT_W = 8
) (
    input  logic [MANT_W:0]   a,
    input  logic [2:0]        grp,
    output logic [MANT_W+2:0] pp
);

    pp_t               sel;
    logic [MANT_W+2:0] mag;

    always_comb begin
        sel = booth_sel(grp);
        mag = '0;
        if (sel.two) begin
            mag = {1'b0, a, 1'b0};
        end else if (sel.one) begin
            mag = {2'b00, a};
        end
        pp = sel.neg ? -mag : mag;
    end

endmodule

// File: rtl/vp_mant_mult_pipe.sv
// vp_mant_mult_pipe: pipelined masked Booth mantissa multiplier, redundant out.
// VP_MANT_MULT_CPA_EN adds a carry-propagate stage and the prod port.
module vp_mant_mult_pipe
    import vp_mult_pkg::*;
#(
    parameter  int MANT_W    = 8,
    parameter  int TRUNC_LSB = 5,
    localparam int PROD_W    = prod_w(MANT_W),
    localparam int MASK_W    = mask_w(MANT_W, TRUNC_LSB)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MASK_W-1:0] mask,
    input  logic [MANT_W-1:0] manta,
    input  logic [MANT_W-1:0] mantb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] mults,
    output logic [PROD_W-1:0] multc,
`ifdef VP_MANT_MULT_CPA_EN
    output logic [PROD_W-1:0] prod,
`endif
    output logic              out_sign
);

    localparam int MAG_W = MANT_W + 1;
    localparam int PP_W  = MANT_W + 3;
    localparam int NPP   = num_pp(MANT_W);
    localparam int EXT_W = 2 * NPP + 1;

    logic              adv;
    logic              s1_valid;
    logic [MAG_W-1:0]  s1_ma;
    logic [MAG_W-1:0]  s1_mb;
    logic [MASK_W-1:0] s1_mask;
    logic              s1_sign;
    logic [MANT_W-1:0] ma_neg;
    logic [MANT_W-1:0] mb_neg;
    logic [EXT_W-1:0]  mb_ext;
    logic [PROD_W-1:0] tmask;
    logic [PROD_W-1:0] pp_m [NPP];
    logic [PROD_W-1:0] cs;
    logic [PROD_W-1:0] ct;
    logic [PROD_W-1:0] cc;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign ma_neg   = -manta;
    assign mb_neg   = -mantb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_ma   <= {1'b0, manta[MANT_W-1] ? ma_neg : manta};
            s1_mb   <= {1'b0, mantb[MANT_W-1] ? mb_neg : mantb};
            s1_mask <= mask;
            s1_sign <= manta[MANT_W-1] ^ mantb[MANT_W-1];
        end
    end

    // b[-1] = 0 below the LSB, zero padding above the magnitude
    assign mb_ext = EXT_W'({s1_mb, 1'b0});
    assign tmask  = {1'b1, s1_mask, {TRUNC_LSB{1'b0}}};

    for (genvar i = 0; i < NPP; i++) begin : g_pp
        logic [PP_W-1:0] raw;

        vp_booth_pp #(
            .MANT_W(MANT_W)
        ) u_booth (
            .a  (s1_ma),
            .grp(mb_ext[2*i +: 3]),
            .pp (raw)
        );

        assign pp_m[i] = ({{(PROD_W-PP_W){raw[PP_W-1]}}, raw} << (2 * i)) & tmask;
    end

    // linear 3:2 chain; each carry re-enters the next level at weight x2
    always_comb begin
        cs = pp_m[0];
        ct = pp_m[1];
        cc = '0;
        for (int i = 2; i < NPP; i++) begin
            cc = (cs & ct) | (cs & pp_m[i]) | (ct & pp_m[i]);
            cs = cs ^ ct ^ pp_m[i];
            ct = cc << 1;
        end
    end

`ifdef VP_MANT_MULT_CPA_EN
    logic              s2_valid;
    logic [PROD_W-1:0] s2_s;
    logic [PROD_W-1:0] s2_c;
    logic              s2_sign;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s2_s    <= cs;
            s2_c    <= cc;
            s2_sign <= s1_sign;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            mults     <= '0;
            multc     <= '0;
            prod      <= '0;
            out_sign  <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid;
            mults     <= s2_s;
            multc     <= s2_c;
            prod      <= s2_s + {s2_c[PROD_W-2:0], 1'b0};
            out_sign  <= s2_sign;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            mults     <= '0;
            multc     <= '0;
            out_sign  <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            mults     <= cs;
            multc     <= cc;
            out_sign  <= s1_sign;
        end
    end
`endif

endmodule
